// File: rtl/hr_pkg.sv
// Shared types, widths and default tuning for the heart-rate sequencer.
package hr_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DETECT} hr_state_t;

  localparam int unsigned BPM_W      = 8;
  localparam int unsigned PEAK_CNT_W = 6;

  localparam int unsigned DEF_SAMPLE_W       = 10;
  localparam int unsigned DEF_WINDOW_SAMPLES = 3000;
  localparam int unsigned DEF_REFRACTORY     = 60;
  localparam int unsigned DEF_BPM_SHIFT      = 2;
  localparam int unsigned DEF_FILT_TIMEOUT   = 15;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_w(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/heart_rate_sequencer_if.sv
// Sample capture and FIR step/result handshake seen by the sequencer.
interface heart_rate_sequencer_if #(
  parameter int unsigned SAMPLE_W = hr_pkg::DEF_SAMPLE_W
);

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                filt_en;
  logic [SAMPLE_W-1:0] filt_in;
  logic                filt_valid;
  logic [SAMPLE_W-1:0] filt_out;

  modport master (
    input  sample_valid, sample, filt_valid, filt_out,
    output filt_en, filt_in
  );

  modport slave (
    output sample_valid, sample, filt_valid, filt_out,
    input  filt_en, filt_in
  );

endinterface

// File: rtl/beat_detector.sv
// Three-point peak test on the filtered stream with threshold and refractory gating.
module beat_detector
  import hr_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
  parameter int unsigned REFRACTORY = DEF_REFRACTORY
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                shift_i,
  input  logic                eval_i,
  input  logic [SAMPLE_W-1:0] filt_i,
  input  logic [SAMPLE_W-1:0] threshold_i,
  output logic                beat_o
);

  localparam int unsigned RefW = cnt_w(REFRACTORY);

  logic [SAMPLE_W-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d;
  logic [1:0]          primed_q, primed_d;
  logic [RefW-1:0]     refr_q, refr_d;
  logic                peak;

  always_comb begin
    // y1 is the candidate peak: strictly above the older point, not below the newer one.
    peak = (primed_q == 2'd3) && (y1_q > y2_q) && (y1_q >= y0_q) &&
           (y1_q >= threshold_i) && (refr_q == '0);
    beat_o   = eval_i & peak;
    y0_d     = y0_q;
    y1_d     = y1_q;
    y2_d     = y2_q;
    primed_d = primed_q;
    refr_d   = refr_q;
    if (shift_i) begin
      y0_d = filt_i;
      y1_d = y0_q;
      y2_d = y1_q;
      if (primed_q != 2'd3) primed_d = primed_q + 2'd1;
    end
    if (eval_i) begin
      if (peak)               refr_d = RefW'(REFRACTORY);
      else if (refr_q != '0)  refr_d = refr_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      y0_q     <= '0;
      y1_q     <= '0;
      y2_q     <= '0;
      primed_q <= '0;
      refr_q   <= '0;
    end else begin
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      y2_q     <= y2_d;
      primed_q <= primed_d;
      refr_q   <= refr_d;
    end
  end

endmodule

// File: rtl/heart_rate_sequencer.sv
// Per-sample FIR sequencing, beat detection and windowed BPM publication.
module heart_rate_sequencer
  import hr_pkg::*;
#(
  parameter int unsigned SAMPLE_W       = DEF_SAMPLE_W,
  parameter int unsigned WINDOW_SAMPLES = DEF_WINDOW_SAMPLES,
  parameter int unsigned BPM_SHIFT      = DEF_BPM_SHIFT,
  parameter int unsigned REFRACTORY     = DEF_REFRACTORY,
  parameter int unsigned FILT_TIMEOUT   = DEF_FILT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  heart_rate_sequencer_if.master hr_if,
  input  logic [SAMPLE_W-1:0]    threshold,
  output logic                   beat,
  output logic [BPM_W-1:0]       bpm,
  output logic                   bpm_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned TmoW = cnt_w(FILT_TIMEOUT - 1);
  localparam int unsigned WinW = cnt_w(WINDOW_SAMPLES - 1);

  hr_state_t             state_q, state_d;
  logic [SAMPLE_W-1:0]   filt_in_q, filt_in_d;
  logic                  filt_en_q, filt_en_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [WinW-1:0]       win_q, win_d;
  logic [PEAK_CNT_W-1:0] peak_q, peak_d, peak_inc;
  logic [BPM_W-1:0]      bpm_q, bpm_d;
  logic [31:0]           scaled;
  logic                  shift, eval;

  assign shift = (state_q == WAIT) && hr_if.filt_valid;
  assign eval  = (state_q == DETECT);

  beat_detector #(
    .SAMPLE_W   (SAMPLE_W),
    .REFRACTORY (REFRACTORY)
  ) u_beat_detector (
    .clk_i       (clk),
    .rst_ni      (reset),
    .shift_i     (shift),
    .eval_i      (eval),
    .filt_i      (hr_if.filt_out),
    .threshold_i (threshold),
    .beat_o      (beat)
  );

  always_comb begin
    state_d   = state_q;
    filt_in_d = filt_in_q;
    tmo_d     = tmo_q;
    overrun_d = overrun_q;
    win_d     = win_q;
    peak_d    = peak_q;
    bpm_d     = bpm_q;
    bpm_valid = 1'b0;
    peak_inc  = peak_q;
    scaled    = '0;
    // Any sample arriving while a previous one is still in flight is lost.
    if (hr_if.sample_valid && (state_q != IDLE)) overrun_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (hr_if.sample_valid) begin
          filt_in_d = hr_if.sample;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (hr_if.filt_valid) begin
          state_d = DETECT;
        end else if (tmo_q == TmoW'(FILT_TIMEOUT - 1)) begin
          overrun_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DETECT: begin
        state_d = IDLE;
        if (beat && (peak_q != '1)) peak_inc = peak_q + 1'b1;
        if (win_q == WinW'(WINDOW_SAMPLES - 1)) begin
          scaled    = 32'(peak_inc) << BPM_SHIFT;
          bpm_d     = (scaled > 32'd255) ? '1 : scaled[BPM_W-1:0];
          bpm_valid = 1'b1;
          win_d     = '0;
          peak_d    = '0;
        end else begin
          win_d  = win_q + 1'b1;
          peak_d = peak_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    filt_en_d = (state_d == ISSUE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      filt_in_q <= '0;
      filt_en_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      tmo_q     <= '0;
      win_q     <= '0;
      peak_q    <= '0;
      bpm_q     <= '0;
    end else begin
      state_q   <= state_d;
      filt_in_q <= filt_in_d;
      filt_en_q <= filt_en_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      tmo_q     <= tmo_d;
      win_q     <= win_d;
      peak_q    <= peak_d;
      bpm_q     <= bpm_d;
    end
  end

  assign hr_if.filt_en = filt_en_q;
  assign hr_if.filt_in = filt_in_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
  assign bpm           = bpm_q;

endmodule

// File: tb/tb_heart_rate_sequencer.sv
// Two sequencers with different window/refractory/shift settings share one stimulus stream.
module tb_heart_rate_sequencer;
  import hr_pkg::*;

  localparam int unsigned SW = 10;
  localparam int NI = 2;

  localparam int unsigned WIN_A = 20,  REF_A = 3, SH_A = 2;
  localparam int unsigned WIN_B = 200, REF_B = 0, SH_B = 3;

  logic          clk, reset;
  logic          sv, fv;
  logic [SW-1:0] smp, fo, th;

  logic          beat_o [NI];
  logic [7:0]    bpm_o  [NI];
  logic          bv_o   [NI];
  logic          busy_o [NI];
  logic          ov_o   [NI];
  logic          fe_o   [NI];
  logic [SW-1:0] fi_o   [NI];

  heart_rate_sequencer_if #(.SAMPLE_W(SW)) if_a ();
  heart_rate_sequencer_if #(.SAMPLE_W(SW)) if_b ();

  assign if_a.sample_valid = sv;
  assign if_a.sample       = smp;
  assign if_a.filt_valid   = fv;
  assign if_a.filt_out     = fo;
  assign if_b.sample_valid = sv;
  assign if_b.sample       = smp;
  assign if_b.filt_valid   = fv;
  assign if_b.filt_out     = fo;
  assign fe_o[0] = if_a.filt_en;
  assign fi_o[0] = if_a.filt_in;
  assign fe_o[1] = if_b.filt_en;
  assign fi_o[1] = if_b.filt_in;

  heart_rate_sequencer #(
    .SAMPLE_W(SW), .WINDOW_SAMPLES(WIN_A), .BPM_SHIFT(SH_A), .REFRACTORY(REF_A),
    .FILT_TIMEOUT(15)
  ) u_dut_a (
    .clk(clk), .reset(reset), .hr_if(if_a), .threshold(th), .beat(beat_o[0]),
    .bpm(bpm_o[0]), .bpm_valid(bv_o[0]), .busy(busy_o[0]), .overrun(ov_o[0])
  );

  heart_rate_sequencer #(
    .SAMPLE_W(SW), .WINDOW_SAMPLES(WIN_B), .BPM_SHIFT(SH_B), .REFRACTORY(REF_B),
    .FILT_TIMEOUT(15)
  ) u_dut_b (
    .clk(clk), .reset(reset), .hr_if(if_b), .threshold(th), .beat(beat_o[1]),
    .bpm(bpm_o[1]), .bpm_valid(bv_o[1]), .busy(busy_o[1]), .overrun(ov_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, one set per instance.
  int hist      [NI][3];
  int n_acc     [NI];
  int det_idx   [NI];
  int last_beat [NI];
  int win_pos   [NI];
  int pk        [NI];
  int exp_beat  [NI];
  int exp_bv    [NI];
  int exp_bpm   [NI];
  int exp_ov;

  function automatic int win_of(int i);
    return (i == 0) ? WIN_A : WIN_B;
  endfunction
  function automatic int ref_of(int i);
    return (i == 0) ? REF_A : REF_B;
  endfunction
  function automatic int sh_of(int i);
    return (i == 0) ? SH_A : SH_B;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 3; k++) hist[i][k] = 0;
      n_acc[i] = 0; det_idx[i] = 0; last_beat[i] = -1;
      win_pos[i] = 0; pk[i] = 0; exp_bpm[i] = 0; exp_beat[i] = 0; exp_bv[i] = 0;
    end
    exp_ov = 0;
  endtask

  // Beat allowed once more than REFRACTORY detects have passed since the last beat.
  task automatic model_detect(input int i, input int f, input int thr);
    int     scaled;
    logic   pk_now;
    hist[i][2] = hist[i][1];
    hist[i][1] = hist[i][0];
    hist[i][0] = f;
    if (n_acc[i] < 3) n_acc[i]++;
    det_idx[i]++;
    pk_now = (n_acc[i] == 3) && (hist[i][1] > hist[i][2]) && (hist[i][1] >= hist[i][0]) &&
             (hist[i][1] >= thr) &&
             ((last_beat[i] < 0) || (det_idx[i] - last_beat[i] > ref_of(i)));
    if (pk_now) begin
      last_beat[i] = det_idx[i];
      if (pk[i] < 63) pk[i]++;
    end
    exp_beat[i] = pk_now ? 1 : 0;
    exp_bv[i]   = 0;
    win_pos[i]++;
    if (win_pos[i] == win_of(i)) begin
      scaled     = pk[i] * (1 << sh_of(i));
      exp_bpm[i] = (scaled > 255) ? 255 : scaled;
      exp_bv[i]  = 1;
      win_pos[i] = 0;
      pk[i]      = 0;
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s.filt_en[%0d]", tag, i), fe_o[i], 0);
      check_eq($sformatf("%s.filt_in[%0d]", tag, i), fi_o[i], 0);
      check_eq($sformatf("%s.beat[%0d]", tag, i), beat_o[i], 0);
      check_eq($sformatf("%s.bpm[%0d]", tag, i), bpm_o[i], 0);
      check_eq($sformatf("%s.bpm_valid[%0d]", tag, i), bv_o[i], 0);
      check_eq($sformatf("%s.busy[%0d]", tag, i), busy_o[i], 0);
      check_eq($sformatf("%s.overrun[%0d]", tag, i), ov_o[i], 0);
    end
  endtask

  // One sample transaction; dly = idle WAIT cycles before filt_valid, tmo = never answer.
  task automatic do_sample(input int s, input int f, input int thr, input int dly,
                           input bit tmo, input bit inj);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_eq($sformatf("idle.busy[%0d]", i), busy_o[i], 0);
    th = SW'(thr); sv = 1'b1; smp = SW'(s);
    @(negedge clk);
    sv = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("issue.filt_en[%0d]", i), fe_o[i], 1);
      check_eq($sformatf("issue.filt_in[%0d]", i), fi_o[i], s);
      check_eq($sformatf("issue.busy[%0d]", i), busy_o[i], 1);
    end
    if (inj) exp_ov = 1;
    if (tmo) begin
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        sv = (inj && k == 0);
        smp = SW'(s + 1);
      end
      for (int i = 0; i < NI; i++) check_eq($sformatf("tmo.busy_last[%0d]", i), busy_o[i], 1);
      @(negedge clk);
      sv = 1'b0;
      exp_ov = 1;
      for (int i = 0; i < NI; i++) begin
        check_eq($sformatf("tmo.busy[%0d]", i), busy_o[i], 0);
        check_eq($sformatf("tmo.overrun[%0d]", i), ov_o[i], 1);
        check_eq($sformatf("tmo.filt_en[%0d]", i), fe_o[i], 0);
      end
      return;
    end
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      sv = (inj && k == 0);
      fv = 1'b0;
      check_eq("wait.filt_en", fe_o[0], 0);
    end
    @(negedge clk);
    sv = (inj && dly == 0);
    fv = 1'b1; fo = SW'(f);
    @(negedge clk);
    sv = 1'b0; fv = 1'b0; fo = SW'($urandom_range(0, 1023));
    for (int i = 0; i < NI; i++) begin
      model_detect(i, f, thr);
      check_eq($sformatf("detect.beat[%0d]", i), beat_o[i], exp_beat[i]);
      check_eq($sformatf("detect.bpm_valid[%0d]", i), bv_o[i], exp_bv[i]);
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("post.busy[%0d]", i), busy_o[i], 0);
      check_eq($sformatf("post.filt_en[%0d]", i), fe_o[i], 0);
      check_eq($sformatf("post.beat[%0d]", i), beat_o[i], 0);
      check_eq($sformatf("post.bpm[%0d]", i), bpm_o[i], exp_bpm[i]);
      check_eq($sformatf("post.overrun[%0d]", i), ov_o[i], exp_ov);
    end
  endtask

  int dir_v [20] = '{100, 200, 150, 300, 250, 50, 80, 60, 10, 100,
                     50, 20, 10, 100, 50, 20, 10, 10, 10, 10};
  int dir_t [20] = '{120, 120, 120, 120, 120, 120, 120, 120, 40, 40,
                     40, 40, 40, 40, 40, 40, 40, 40, 40, 40};

  initial begin
    int pick, dly;
    reset = 1'b0; sv = 1'b1; smp = SW'(77); fv = 1'b1; fo = SW'(500); th = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1; sv = 1'b0; fv = 1'b0;
    @(negedge clk);
    check_cleared("reset");

    for (int n = 0; n < 20; n++) do_sample(n + 1, dir_v[n], dir_t[n], 1, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      pick = $urandom_range(0, 4);
      dly  = (pick == 4) ? 14 : pick;
      do_sample($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 700),
                dly, 1'b0, 1'b0);
    end

    do_sample(11, 400, 100, 2, 1'b0, 1'b1);
    do_sample(12, 300, 100, 0, 1'b1, 1'b0);
    do_sample(13, 350, 100, 0, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      pick = $urandom_range(0, 4);
      dly  = (pick == 4) ? 14 : pick;
      do_sample($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 500),
                dly, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
    end

    // Reset while a filter result is being returned: nothing may come out of it.
    @(negedge clk);
    th = '0; sv = 1'b1; smp = SW'(5);
    @(negedge clk);
    sv = 1'b0;
    @(negedge clk);
    reset = 1'b0; fv = 1'b1; fo = SW'(900);
    @(negedge clk);
    fv = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_cleared("midreset");

    // Alternating low/high stream saturates the peak count and the BPM output.
    for (int n = 0; n < 420; n++) do_sample(n, (n % 2 == 0) ? 100 : 900, 0, 0, 1'b0, 1'b0);
    check_eq("sat.bpm_b", bpm_o[1], 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
